// File: rtl/uart_transmitter_if.sv
// ---------------------------------------------------------------------------
// uart_transmitter_if
//   Groups the host-side byte handshake and the serial line of
//   uart_transmitter into one bundle.
//
//   Signals
//     Tx_DATA      byte to send, sampled on the accept edge
//     baud_select  rate code (000=300 ... 111=115200 baud)
//     Tx_EN        transmitter enable
//     Tx_WR        one-cycle write strobe
//     TxD          serial line, idle high
//     Tx_BUSY      frame in progress
//     Tx_DONE      one-cycle pulse at the end of the stop bit
//     Tx_HOLD_FULL holding register occupied (UART_TX_DBLBUF_EN only)
//
//   Modports
//     master  host / bench side: drives data and controls, observes line
//     slave   transmitter side
//
//   Optional feature macro: UART_TX_DBLBUF_EN
// ---------------------------------------------------------------------------
interface uart_transmitter_if;
    logic [7:0] Tx_DATA;
    logic [2:0] baud_select;
    logic       Tx_EN;
    logic       Tx_WR;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_DONE;
`ifdef UART_TX_DBLBUF_EN
    logic       Tx_HOLD_FULL;

    modport master (
        output Tx_DATA, baud_select, Tx_EN, Tx_WR,
        input  TxD, Tx_BUSY, Tx_DONE, Tx_HOLD_FULL
    );
    modport slave (
        input  Tx_DATA, baud_select, Tx_EN, Tx_WR,
        output TxD, Tx_BUSY, Tx_DONE, Tx_HOLD_FULL
    );
`else
    modport master (
        output Tx_DATA, baud_select, Tx_EN, Tx_WR,
        input  TxD, Tx_BUSY, Tx_DONE
    );
    modport slave (
        input  Tx_DATA, baud_select, Tx_EN, Tx_WR,
        output TxD, Tx_BUSY, Tx_DONE
    );
`endif
endinterface

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//   Sends one byte per accepted write as an 8E1 frame on TxD:
//   start (0), 8 data bits LSB first, even parity, stop (1).
//   A private 16x baud tick generator times every bit; the line is
//   registered so it can feed a uart_receiver RxD directly.
//
//   Parameters
//     CLK_HZ      system clock frequency in Hz
//     OVERSAMPLE  baud ticks per bit (fixed at 16, matches the receiver)
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-high
//     bus    uart_transmitter_if.slave (data, rate, enable, write,
//            TxD, Tx_BUSY, Tx_DONE [, Tx_HOLD_FULL])
//
//   Optional feature macro: UART_TX_DBLBUF_EN
//     Adds a one-byte holding register so a frame written while busy
//     follows the current one with no idle gap.
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               reset,
    uart_transmitter_if.slave  bus
);

    // Rounded tick divisor: clk cycles per 1/16 bit.
    function automatic int divisor(input int baud);
        return (CLK_HZ + 8 * baud) / (16 * baud);
    endfunction

    localparam int DIV_W = $clog2(divisor(300) + 1);

    typedef logic [DIV_W-1:0] div_t;

    // Terminal count (DIV-1) for each rate code; a pure constant mux.
    function automatic div_t div_m1_for(input logic [2:0] sel);
        case (sel)
            3'd0:    return div_t'(divisor(300)    - 1);
            3'd1:    return div_t'(divisor(1200)   - 1);
            3'd2:    return div_t'(divisor(4800)   - 1);
            3'd3:    return div_t'(divisor(9600)   - 1);
            3'd4:    return div_t'(divisor(19200)  - 1);
            3'd5:    return div_t'(divisor(38400)  - 1);
            3'd6:    return div_t'(divisor(57600)  - 1);
            default: return div_t'(divisor(115200) - 1);
        endcase
    endfunction

    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state_q, state_d;
    div_t       tick_cnt_q, tick_cnt_d;
    div_t       div_m1_q, div_m1_d;      // rate latched for the current frame
    logic [3:0] sample_cnt_q, sample_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] data_q, data_d;
    logic       txd_q, txd_d;
    logic       done_q, done_d;

    logic       tick;
    logic       bit_end;
    logic [2:0] bit_idx_nx;

`ifdef UART_TX_DBLBUF_EN
    logic [7:0] hold_q, hold_d;
    div_t       hold_div_m1_q, hold_div_m1_d;
    logic       hold_full_q, hold_full_d;
`endif

    assign tick       = (tick_cnt_q == div_m1_q);
    assign bit_end    = tick && (sample_cnt_q == SAMPLE_LAST);
    assign bit_idx_nx = bit_idx_q + 3'd1;

    always_comb begin
        // NOTE: every signal gets a default before any branch so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        data_d       = data_q;
        div_m1_d     = div_m1_q;
        txd_d        = txd_q;
        done_d       = 1'b0;
`ifdef UART_TX_DBLBUF_EN
        hold_d        = hold_q;
        hold_div_m1_d = hold_div_m1_q;
        hold_full_d   = hold_full_q;
`endif

        if (!bus.Tx_EN) begin
            // Disable aborts immediately: line idles, nothing is kept.
            state_d      = IDLE;
            tick_cnt_d   = '0;
            sample_cnt_d = '0;
            bit_idx_d    = '0;
            txd_d        = 1'b1;
`ifdef UART_TX_DBLBUF_EN
            hold_full_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Tx_WR) begin
                        state_d      = START;
                        data_d       = bus.Tx_DATA;
                        div_m1_d     = div_m1_for(bus.baud_select);
                        tick_cnt_d   = '0;
                        sample_cnt_d = '0;
                        bit_idx_d    = '0;
                        txd_d        = 1'b0;
                    end
                end

                default: begin
                    if (tick) begin
                        tick_cnt_d   = '0;
                        sample_cnt_d = sample_cnt_q + 4'd1;  // wraps to 0 at bit end
                    end else begin
                        tick_cnt_d   = tick_cnt_q + div_t'(1);
                    end

                    if (bit_end) begin
                        case (state_q)
                            START: begin
                                state_d   = DATA;
                                bit_idx_d = '0;
                                txd_d     = data_q[0];
                            end
                            DATA: begin
                                if (bit_idx_q == 3'd7) begin
                                    state_d = PARITY;
                                    txd_d   = ^data_q;
                                end else begin
                                    bit_idx_d = bit_idx_nx;
                                    txd_d     = data_q[bit_idx_nx];
                                end
                            end
                            PARITY: begin
                                state_d = STOP;
                                txd_d   = 1'b1;
                            end
                            default: begin  // STOP
                                done_d = 1'b1;
`ifdef UART_TX_DBLBUF_EN
                                if (hold_full_q) begin
                                    // Back-to-back: START begins on this edge.
                                    state_d      = START;
                                    data_d       = hold_q;
                                    div_m1_d     = hold_div_m1_q;
                                    tick_cnt_d   = '0;
                                    sample_cnt_d = '0;
                                    bit_idx_d    = '0;
                                    txd_d        = 1'b0;
                                    hold_full_d  = 1'b0;
                                end else begin
                                    state_d = IDLE;
                                    txd_d   = 1'b1;
                                end
`else
                                state_d = IDLE;
                                txd_d   = 1'b1;
`endif
                            end
                        endcase
                    end
                end
            endcase

`ifdef UART_TX_DBLBUF_EN
            // While busy an empty holder takes the write; a full one drops it.
            // A holder consumed on this edge was full, so it is not refilled.
            if (bus.Tx_WR && (state_q != IDLE) && !hold_full_q) begin
                hold_d        = bus.Tx_DATA;
                hold_div_m1_d = div_m1_for(bus.baud_select);
                hold_full_d   = 1'b1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values of the previous cycle regardless of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            div_m1_q     <= '0;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            data_q       <= '0;
            txd_q        <= 1'b1;
            done_q       <= 1'b0;
`ifdef UART_TX_DBLBUF_EN
            hold_q        <= '0;
            hold_div_m1_q <= '0;
            hold_full_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            div_m1_q     <= div_m1_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            txd_q        <= txd_d;
            done_q       <= done_d;
`ifdef UART_TX_DBLBUF_EN
            hold_q        <= hold_d;
            hold_div_m1_q <= hold_div_m1_d;
            hold_full_q   <= hold_full_d;
`endif
        end
    end

    assign bus.TxD     = txd_q;
    assign bus.Tx_BUSY = (state_q != IDLE);
    assign bus.Tx_DONE = done_q;
`ifdef UART_TX_DBLBUF_EN
    assign bus.Tx_HOLD_FULL = hold_full_q;
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//   Directed bench for uart_transmitter at 100 MHz, 115200 baud
//   (bit = 864 cycles, frame = 9504 cycles). Inputs change 1 ns after a
//   rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int BIT   = 864;
    localparam int FRAME = 11 * BIT;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_transmitter_if bus ();

    uart_transmitter #(
        .CLK_HZ     (100_000_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write strobe; returns 1 ns after the accept edge.
    task automatic send(input logic [7:0] d, input logic [2:0] sel);
        bus.Tx_DATA     = d;
        bus.baud_select = sel;
        bus.Tx_WR       = 1'b1;
        step();
        bus.Tx_WR       = 1'b0;
    endtask

    // Follows one frame from 1 ns after its accept edge up to its done edge.
    // Optionally issues a write at cycle wr_at and sets baud_select at cycle 500.
    task automatic check_frame(input logic [7:0] d, input int wr_at,
                               input logic [7:0] wr_data, input logic chained,
                               input logic [2:0] sel_at_500);
        logic [10:0] frame;
        int          early_done;
        frame      = {1'b1, ^d, d, 1'b0};
        early_done = 0;
        for (int c = 1; c <= FRAME; c++) begin
            if (c == wr_at) begin
                bus.Tx_DATA = wr_data;
                bus.Tx_WR   = 1'b1;
            end
            if (c == 500) bus.baud_select = sel_at_500;
            step();
            bus.Tx_WR = 1'b0;
            if (c == 1) check("done_low_after_start", bus.Tx_DONE, 1'b0);
            if (c % BIT == BIT / 2)
                check($sformatf("frame_%02h_bit%0d", d, c / BIT), bus.TxD, frame[c / BIT]);
            if (c == FRAME - 1) check("busy_before_end", bus.Tx_BUSY, 1'b1);
            if (c < FRAME && bus.Tx_DONE) early_done++;
`ifdef UART_TX_DBLBUF_EN
            if (wr_at != 0 && c == wr_at) check("hold_full_after_write", bus.Tx_HOLD_FULL, 1'b1);
`endif
        end
        check("no_early_done", early_done, 0);
        check("done_pulse", bus.Tx_DONE, 1'b1);
        check("busy_at_end", bus.Tx_BUSY, chained);
        check("txd_at_end", bus.TxD, !chained);
    endtask

    // Watches a full frame time and counts any busy or done activity.
    task automatic expect_quiet(input string tag);
        int act;
        act = 0;
        for (int c = 0; c < FRAME; c++) begin
            step();
            if (bus.Tx_DONE || bus.Tx_BUSY || !bus.TxD) act++;
        end
        check(tag, act, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        bus.Tx_DATA     = 8'h00;
        bus.baud_select = 3'b111;
        bus.Tx_EN       = 1'b0;
        bus.Tx_WR       = 1'b0;

        // Reset for 1000 ns.
        #1000;
        check("reset_txd",  bus.TxD, 1'b1);
        check("reset_busy", bus.Tx_BUSY, 1'b0);
        check("reset_done", bus.Tx_DONE, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Idle with a write while disabled: must be ignored.
        send(8'hA5, 3'b111);
        repeat (10) step();
        check("wr_disabled_busy", bus.Tx_BUSY, 1'b0);
        check("wr_disabled_txd",  bus.TxD, 1'b1);
        check("idle_done", bus.Tx_DONE, 1'b0);

        bus.Tx_EN = 1'b1;
        repeat (5) step();

        // 0xA5: parity 0. Write coincident with Tx_DONE is not accepted
        // (without the holder); the following cycle's write is.
        send(8'hA5, 3'b111);
        check("accept_txd",  bus.TxD, 1'b0);
        check("accept_busy", bus.Tx_BUSY, 1'b1);
`ifdef UART_TX_DBLBUF_EN
        check_frame(8'hA5, 0, 8'h00, 1'b0, 3'b111);
`else
        check_frame(8'hA5, FRAME, 8'h77, 1'b0, 3'b111);
`endif
        send(8'h01, 3'b111);
        check("done_drop",        bus.Tx_DONE, 1'b0);
        check("next_cycle_start", bus.Tx_BUSY, 1'b1);

        // 0x01: parity 1; a second write at cycle 500.
`ifdef UART_TX_DBLBUF_EN
        check_frame(8'h01, 500, 8'h3C, 1'b1, 3'b111);
        check_frame(8'h3C, 0, 8'h00, 1'b0, 3'b111);
`else
        check_frame(8'h01, 500, 8'h3C, 1'b0, 3'b111);
`endif
        repeat (20) step();
        check("after_frame_busy", bus.Tx_BUSY, 1'b0);
        check("after_frame_txd",  bus.TxD, 1'b1);
        check("after_frame_done", bus.Tx_DONE, 1'b0);

        // Tx_EN dropped during DATA bit 3 (0xF0 bit 3 = 0).
        send(8'hF0, 3'b111);
        repeat (4 * BIT + 100) step();
        check("en_abort_pre_txd", bus.TxD, 1'b0);
        bus.Tx_EN = 1'b0;
        step();
        check("en_abort_txd",  bus.TxD, 1'b1);
        check("en_abort_busy", bus.Tx_BUSY, 1'b0);
        check("en_abort_done", bus.Tx_DONE, 1'b0);
        expect_quiet("en_abort_quiet");
        bus.Tx_EN = 1'b1;
        step();

        // Reset during DATA bit 3: asynchronous, no clock edge needed.
        send(8'hF0, 3'b111);
        repeat (4 * BIT + 100) step();
        check("rst_abort_pre_txd", bus.TxD, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_abort_txd",  bus.TxD, 1'b1);
        check("rst_abort_busy", bus.Tx_BUSY, 1'b0);
        check("rst_abort_done", bus.Tx_DONE, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        expect_quiet("rst_abort_quiet");

        // Rate change mid-frame: current frame unaffected, next frame slow.
        send(8'h55, 3'b111);
        check_frame(8'h55, 0, 8'h00, 1'b0, 3'b000);
        step();
        send(8'h01, 3'b000);
        low_cnt = 0;
        for (int c = 0; c < 5000; c++) begin
            step();
            if (!bus.TxD && bus.Tx_BUSY) low_cnt++;
        end
        check("slow_start_bit_held", low_cnt, 5000);
        bus.Tx_EN = 1'b0;
        step();
        check("slow_abort_busy", bus.Tx_BUSY, 1'b0);
        check("slow_abort_txd",  bus.TxD, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
